// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with carry-in.
// The carry chain is cut into STAGES registered slices with valid/ready flow.
module pipe_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             ca,
  output logic             ov
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipe_addsub: illegal WIDTH/STAGES");
  end

  typedef logic [STAGES-1:0][WIDTH-1:0] word_arr_t;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] acc;
  word_arr_t         sum_q, sum_d;
  word_arr_t         a_q, a_d;
  word_arr_t         be_q, be_d;

  logic [WIDTH-1:0] beff;
  logic             c0;

  assign beff = sub ? ~b : b;
  assign c0   = cin ^ sub;

  function automatic logic [SLICE:0] add_slice(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             ci,
    input int               k
  );
    return {1'b0, x[k*SLICE +: SLICE]}
         + {1'b0, y[k*SLICE +: SLICE]}
         + {{SLICE{1'b0}}, ci};
  endfunction

  // Stage k can take a beat if any stage at or
  // after it is empty, or the consumer drains.
  always_comb begin
    acc = '0;
    for (int k = 0; k < STAGES; k++) begin
      acc[k] = out_ready ||
        ((~v_q & ({STAGES{1'b1}} << k)) != '0);
    end
  end

  assign in_ready = acc[0];

  always_comb begin
    logic [SLICE:0]   r;
    logic [WIDTH-1:0] ss;
    v_d   = v_q;
    c_d   = c_q;
    sum_d = sum_q;
    a_d   = a_q;
    be_d  = be_q;
    r     = add_slice(a, beff, c0, 0);
    ss    = '0;
    ss[SLICE-1:0] = r[SLICE-1:0];
    if (acc[0]) begin
      v_d[0]   = in_valid;
      c_d[0]   = r[SLICE];
      sum_d[0] = ss;
      a_d[0]   = a;
      be_d[0]  = beff;
    end
    for (int k = 1; k < STAGES; k++) begin
      r  = add_slice(a_q[k-1], be_q[k-1],
                     c_q[k-1], k);
      ss = sum_q[k-1];
      ss[k*SLICE +: SLICE] = r[SLICE-1:0];
      if (acc[k]) begin
        v_d[k]   = v_q[k-1];
        c_d[k]   = r[SLICE];
        sum_d[k] = ss;
        a_d[k]   = a_q[k-1];
        be_d[k]  = be_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      sum_q <= '0;
      a_q   <= '0;
      be_q  <= '0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      sum_q <= sum_d;
      a_q   <= a_d;
      be_q  <= be_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign s         = sum_q[LAST];
  assign ca        = c_q[LAST];
  assign ov        = (a_q[LAST][MSB] == be_q[LAST][MSB]) &&
                     (sum_q[LAST][MSB] != a_q[LAST][MSB]);

  // Only the sign bits of the last stage's operands feed ov.
  logic unused_last;
  assign unused_last = ^{a_q[LAST], be_q[LAST]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed steps on STAGES=2 plus
// scoreboards on STAGES=1,2,4,8 instances sharing stimulus.
module tb_pipe_addsub;

  localparam int W = 8;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         iv   = 1'b0;
  logic         subv = 1'b0;
  logic         cinv = 1'b0;
  logic         ordy = 1'b1;
  logic [W-1:0] av   = '0;
  logic [W-1:0] bv   = '0;

  logic         rdy [4];
  logic         vld [4];
  logic         caw [4];
  logic         ovw [4];
  logic [W-1:0] sw  [4];

  int checks   = 0;
  int failures = 0;
  int pend [4];

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         sb,
    input logic         ci
  );
    int ux, uy, sx, sy, r, sr;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      r  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      c  = (r >= 256);
    end else begin
      r  = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      c  = (r >= 0);
    end
    o = (sr > 127) || (sr < -128);
    return {c, o, r[W-1:0]};
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int ST = 1 << gi;
    logic [W+1:0] q [$];
    logic [W+1:0] exp_v;

    pipe_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (rdy[gi]),
      .a         (av),
      .b         (bv),
      .sub       (subv),
      .cin       (cinv),
      .out_valid (vld[gi]),
      .out_ready (ordy),
      .s         (sw[gi]),
      .ca        (caw[gi]),
      .ov        (ovw[gi])
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (vld[gi] && ordy) begin
          checks++;
          assert (q.size() > 0) else begin
            failures++;
            $error("FAIL stale_st%0d got s=%h exp none",
                   ST, sw[gi]);
          end
          if (q.size() > 0) begin
            exp_v = q.pop_front();
            checks++;
            assert ({caw[gi], ovw[gi], sw[gi]} === exp_v)
            else begin
              failures++;
              $error("FAIL sb_st%0d got=%h exp=%h", ST,
                     {caw[gi], ovw[gi], sw[gi]}, exp_v);
            end
          end
        end
        if (iv && rdy[gi])
          q.push_back(model(av, bv, subv, cinv));
      end
      pend[gi] = q.size();
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic sb, input logic ci);
    iv   = 1'b1;
    av   = x;
    bv   = y;
    subv = sb;
    cinv = ci;
  endtask

  logic [W-1:0] ta [6] = '{8'h3C, 8'hFF, 8'h7F,
                           8'h80, 8'h05, 8'h05};
  logic [W-1:0] tb [6] = '{8'h0F, 8'h01, 8'h01,
                           8'h01, 8'h07, 8'h07};
  logic         tsb[6] = '{1'b0, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b1};
  logic         tci[6] = '{1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b1};
  logic [9:0]   tex[6] = '{10'h04B, 10'h200, 10'h180,
                           10'h37F, 10'h0FE, 10'h0FD};

  int   idx;
  logic took;
  logic hold;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_rdy", 32'(rdy[1]), 32'd1);
    chk("rst_vld", 32'(vld[1]), 32'd0);
    chk("rst_s",   32'(sw[1]),  32'd0);
    chk("rst_caov", 32'({caw[1], ovw[1]}), 32'd0);
    step();
    step();
    rst = 1'b0;
    chk("post_rst_rdy", 32'(rdy[1]), 32'd1);

    // directed arithmetic, streamed back to back
    for (int i = 0; i < 7; i++) begin
      if (i < 6) put(ta[i], tb[i], tsb[i], tci[i]);
      else iv = 1'b0;
      step();
      if (i == 0)
        chk("lat_vld0", 32'(vld[1]), 32'd0);
      else begin
        chk($sformatf("dir_vld%0d", i - 1),
            32'(vld[1]), 32'd1);
        chk($sformatf("dir_res%0d", i - 1),
            32'({caw[1], ovw[1], sw[1]}),
            32'(tex[i-1]));
      end
    end
    for (int i = 0; i < 4; i++) step();

    // backpressure: six beats, consumer stalls 2..5
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      ordy = !((c >= 2) && (c <= 5));
      if (idx <= 6) put(8'(idx), 8'(idx * 2), 1'b0, 1'b0);
      else iv = 1'b0;
      @(negedge clk);
      chk($sformatf("bp_rdy%0d", c), 32'(rdy[1]),
          32'(!((c >= 2) && (c <= 5))));
      if ((c >= 2) && (c <= 5)) begin
        chk($sformatf("bp_vld%0d", c), 32'(vld[1]), 32'd1);
        chk($sformatf("bp_hold%0d", c), 32'(sw[1]), 32'd3);
      end
      took = iv && rdy[1];
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    iv   = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // bubble collapse while the last stage is stalled
    put(8'd10, 8'd20, 1'b0, 1'b0);
    ordy = 1'b0;
    step();
    iv = 1'b0;
    step();
    put(8'd30, 8'd40, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_rdy", 32'(rdy[1]), 32'd1);
    chk("bub_vld", 32'(vld[1]), 32'd1);
    step();
    iv = 1'b0;
    @(negedge clk);
    chk("full_rdy", 32'(rdy[1]), 32'd0);
    chk("full_s", 32'(sw[1]), 32'd30);
    @(posedge clk);
    #1;
    put(8'd50, 8'd60, 1'b0, 1'b0);
    ordy = 1'b1;
    @(negedge clk);
    chk("shift_rdy", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1;
    iv = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // asynchronous reset with two beats in flight
    put(8'd1, 8'd1, 1'b0, 1'b0);
    step();
    put(8'd2, 8'd2, 1'b0, 1'b0);
    step();
    iv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(vld[1]), 32'd0);
    chk("mid_rst_s",   32'(sw[1]),  32'd0);
    chk("mid_rst_rdy", 32'(rdy[1]), 32'd1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), 32'(vld[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    put(8'h21, 8'h12, 1'b0, 1'b0);
    step();
    iv = 1'b0;
    step();
    chk("post_rst_vld", 32'(vld[1]), 32'd1);
    chk("post_rst_s", 32'(sw[1]), 32'h33);

    // random regression, producer holds stalled beats
    hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!hold) begin
        iv   = ($urandom_range(0, 3) != 0);
        av   = 8'($urandom);
        bv   = 8'($urandom);
        subv = 1'($urandom);
        cinv = 1'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = iv && !rdy[1];
      @(posedge clk);
      #1;
    end

    iv   = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 30; i++) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain%0d", i), 32'(pend[i]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
